// File: rtl/mole_draw_scheduler_if.sv
// Pixel-bus and mole-request signals between the game logic, the draw
// scheduler and the VGA frame-buffer adapter.
interface mole_draw_scheduler_if;
  logic [2:0] mole_on;
  logic       clear_req;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;
  logic [2:0] drawn;

  // Scheduler side: takes requests, drives the pixel writes.
  modport master (
    input  mole_on,
    input  clear_req,
    output x,
    output y,
    output colour,
    output plot,
    output busy,
    output done,
    output drawn
  );

  // Requester / frame-buffer side.
  modport slave (
    output mole_on,
    output clear_req,
    input  x,
    input  y,
    input  colour,
    input  plot,
    input  busy,
    input  done,
    input  drawn
  );
endinterface

// File: rtl/mole_draw_scheduler.sv
// Serialises every frame-buffer write for the whack-a-mole screen: a
// full-screen black clear (top priority, never interrupting a fill) and
// per-mole rectangle fills granted round-robin whenever the requested mole
// state differs from what is currently drawn.
module mole_draw_scheduler #(
  parameter int         BOX_W      = 8,
  parameter int         BOX_H      = 8,
  parameter int         X0         = 1,
  parameter int         X_STEP     = 8,
  parameter int         Y0         = 33,
  parameter int         SCR_W      = 160,
  parameter int         SCR_H      = 120,
  parameter logic [2:0] ON_COLOUR  = 3'b100,
  parameter logic [2:0] OFF_COLOUR = 3'b000
) (
  input  logic                   clock,
  input  logic                   resetn,
  mole_draw_scheduler_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  localparam logic [7:0] C_BOX_XL = 8'(BOX_W - 1);
  localparam logic [6:0] C_BOX_YL = 7'(BOX_H - 1);
  localparam logic [7:0] C_SCR_XL = 8'(SCR_W - 1);
  localparam logic [6:0] C_SCR_YL = 7'(SCR_H - 1);

  state_t     r_state;
  logic [7:0] r_cx;
  logic [6:0] r_cy;
  logic [1:0] r_g;
  logic       r_tgt;
  logic [1:0] r_rr;
  logic       r_clear_pending;
  logic [2:0] r_drawn;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_colour;
  logic       r_plot;
  logic       r_done;

  logic [2:0] w_pend;
  logic [1:0] w_i0;
  logic [1:0] w_i1;
  logic [1:0] w_i2;
  logic       w_found;
  logic [1:0] w_g;
  logic [7:0] w_fill_x;
  logic [6:0] w_fill_y;

  assign w_pend   = bus.mole_on ^ r_drawn;
  assign w_fill_x = 8'(X0) + 8'(X_STEP) * {6'b0, r_g} + r_cx;
  assign w_fill_y = 7'(Y0) + r_cy;

  // Round-robin grant: scan from r_rr upward (mod 3), first pending mole wins.
  always_comb begin
    w_i0    = 2'd0;
    w_i1    = 2'd1;
    w_i2    = 2'd2;
    w_found = 1'b0;
    w_g     = 2'd0;
    case (r_rr)
      2'd1: begin
        w_i0 = 2'd1;
        w_i1 = 2'd2;
        w_i2 = 2'd0;
      end
      2'd2: begin
        w_i0 = 2'd2;
        w_i1 = 2'd0;
        w_i2 = 2'd1;
      end
      default: begin
        w_i0 = 2'd0;
        w_i1 = 2'd1;
        w_i2 = 2'd2;
      end
    endcase
    if (w_pend[w_i0]) begin
      w_found = 1'b1;
      w_g     = w_i0;
    end else if (w_pend[w_i1]) begin
      w_found = 1'b1;
      w_g     = w_i1;
    end else if (w_pend[w_i2]) begin
      w_found = 1'b1;
      w_g     = w_i2;
    end
  end

  // Scheduler FSM with registered pixel outputs; clear_pending is set last so
  // a clear_req on the same edge that starts a clear queues one more clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state         <= S_IDLE;
      r_cx            <= '0;
      r_cy            <= '0;
      r_g             <= '0;
      r_tgt           <= 1'b0;
      r_rr            <= '0;
      r_clear_pending <= 1'b1;
      r_drawn         <= '0;
      r_x             <= '0;
      r_y             <= '0;
      r_colour        <= '0;
      r_plot          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // plot is only ever high here on the cycle after a last pixel
          r_plot <= 1'b0;
          r_done <= r_plot;
          if (r_clear_pending) begin
            r_clear_pending <= 1'b0;
            r_cx            <= '0;
            r_cy            <= '0;
            r_state         <= S_CLEAR;
          end else if (w_found) begin
            r_g     <= w_g;
            r_tgt   <= bus.mole_on[w_g];
            r_rr    <= (w_g == 2'd2) ? 2'd0 : w_g + 2'd1;
            r_cx    <= '0;
            r_cy    <= '0;
            r_state <= S_FILL;
          end
        end

        S_FILL: begin
          r_x      <= w_fill_x;
          r_y      <= w_fill_y;
          r_colour <= r_tgt ? ON_COLOUR : OFF_COLOUR;
          r_plot   <= 1'b1;
          r_done   <= 1'b0;
          if (r_cx == C_BOX_XL) begin
            r_cx <= '0;
            r_cy <= r_cy + 7'd1;
            if (r_cy == C_BOX_YL) begin
              r_drawn[r_g] <= r_tgt;
              r_state      <= S_IDLE;
            end
          end else begin
            r_cx <= r_cx + 8'd1;
          end
        end

        S_CLEAR: begin
          r_x      <= r_cx;
          r_y      <= r_cy;
          r_colour <= OFF_COLOUR;
          r_plot   <= 1'b1;
          r_done   <= 1'b0;
          if (r_cx == C_SCR_XL) begin
            r_cx <= '0;
            r_cy <= r_cy + 7'd1;
            if (r_cy == C_SCR_YL) begin
              r_drawn <= '0;
              r_state <= S_IDLE;
            end
          end else begin
            r_cx <= r_cx + 8'd1;
          end
        end

        default: begin
          r_plot  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase

      if (bus.clear_req) begin
        r_clear_pending <= 1'b1;
      end
    end
  end

  assign bus.x      = r_x;
  assign bus.y      = r_y;
  assign bus.colour = r_colour;
  assign bus.plot   = r_plot;
  assign bus.done   = r_done;
  assign bus.drawn  = r_drawn;
  assign bus.busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_mole_draw_scheduler.sv
// Directed bench for mole_draw_scheduler: reset clear, single fills,
// round-robin order, clear queued behind a fill, mid-fill request change,
// and asynchronous reset during a fill.
module tb_mole_draw_scheduler;

  logic clock;
  logic resetn;
  int   n_total;
  int   n_bad;

  mole_draw_scheduler_if bus ();

  mole_draw_scheduler dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Wait for a plot burst (bounded), check its start latency, then every
  // pixel {plot,colour,y,x} in raster order, then the trailing done pulse.
  // act_kind 1 pulses clear_req at pixel act_at; 2 sets mole_on=act_val there.
  task automatic run_chk(input string tag, input int x0, input int w,
                         input int y0, input int h, input logic [2:0] col,
                         input int lat, input int act_at, input int act_kind,
                         input logic [2:0] act_val);
    int n;
    int idx;
    int got;
    int exp;
    n = 0;
    while (bus.plot !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (bus.plot !== 1'b1) begin
      chk({tag, ".timeout"}, 0, 1);
      return;
    end
    chk({tag, ".lat"}, n, lat);
    for (int cy = 0; cy < h; cy++) begin
      for (int cx = 0; cx < w; cx++) begin
        idx = cy * w + cx;
        if (act_kind == 1 && idx == act_at) bus.clear_req = 1'b1;
        if (act_kind == 1 && idx == act_at + 1) bus.clear_req = 1'b0;
        if (act_kind == 2 && idx == act_at) bus.mole_on = act_val;
        got = int'({13'b0, bus.plot, bus.colour, bus.y, bus.x});
        exp = (1 << 18) | (int'(col) << 15) | ((y0 + cy) << 8) | (x0 + cx);
        chk({tag, ".px"}, got, exp);
        @(negedge clock);
      end
    end
    chk({tag, ".plot_end"}, int'(bus.plot), 0);
    chk({tag, ".done"}, int'(bus.done), 1);
  endtask

  initial begin
    int n;
    n_total       = 0;
    n_bad         = 0;
    resetn        = 1'b0;
    bus.mole_on   = 3'b000;
    bus.clear_req = 1'b0;
    repeat (3) @(negedge clock);

    chk("rst.plot",   int'(bus.plot),   0);
    chk("rst.x",      int'(bus.x),      0);
    chk("rst.y",      int'(bus.y),      0);
    chk("rst.colour", int'(bus.colour), 0);
    chk("rst.done",   int'(bus.done),   0);
    chk("rst.drawn",  int'(bus.drawn),  0);
    chk("rst.busy",   int'(bus.busy),   0);

    // Post-reset full clear
    resetn = 1'b1;
    run_chk("clr0", 0, 160, 0, 120, 3'b000, 2, -1, 0, 3'b000);
    chk("clr0.drawn", int'(bus.drawn), 0);
    chk("clr0.busy",  int'(bus.busy),  0);

    // Mole 0 up, then back down (leaves rr_ptr=1, drawn=000)
    bus.mole_on = 3'b001;
    run_chk("m0on", 1, 8, 33, 8, 3'b100, 2, -1, 0, 3'b000);
    chk("m0on.drawn", int'(bus.drawn), 1);
    chk("m0on.busy",  int'(bus.busy),  0);
    bus.mole_on = 3'b000;
    run_chk("m0off", 1, 8, 33, 8, 3'b000, 2, -1, 0, 3'b000);
    chk("m0off.drawn", int'(bus.drawn), 0);

    // All three up at once: order 1, 2, 0 with one idle cycle between fills
    bus.mole_on = 3'b111;
    run_chk("rr1", 9, 8, 33, 8, 3'b100, 2, -1, 0, 3'b000);
    chk("rr1.busy", int'(bus.busy), 1);
    run_chk("rr2", 17, 8, 33, 8, 3'b100, 1, -1, 0, 3'b000);
    run_chk("rr0", 1, 8, 33, 8, 3'b100, 1, -1, 0, 3'b000);
    chk("rr.drawn", int'(bus.drawn), 7);
    chk("rr.busy",  int'(bus.busy),  0);

    // clear_req at pixel 20 of a fill: fill finishes, then a full clear
    bus.mole_on = 3'b011;
    run_chk("fclr", 17, 8, 33, 8, 3'b000, 2, 20, 1, 3'b000);
    chk("fclr.drawn", int'(bus.drawn), 3);
    chk("fclr.busy",  int'(bus.busy),  1);
    run_chk("clr1", 0, 160, 0, 120, 3'b000, 1, 100, 2, 3'b000);
    chk("clr1.drawn", int'(bus.drawn), 0);
    chk("clr1.busy",  int'(bus.busy),  0);

    // Request withdrawn mid-fill: fill completes, then an erase fill
    bus.mole_on = 3'b010;
    run_chk("m1", 9, 8, 33, 8, 3'b100, 2, 30, 2, 3'b000);
    chk("m1.drawn", int'(bus.drawn), 2);
    chk("m1.busy",  int'(bus.busy),  1);
    run_chk("m1off", 9, 8, 33, 8, 3'b000, 1, -1, 0, 3'b000);
    chk("m1off.drawn", int'(bus.drawn), 0);

    // Nothing pending: scheduler stays idle
    repeat (5) @(negedge clock);
    chk("idle.plot", int'(bus.plot), 0);
    chk("idle.busy", int'(bus.busy), 0);

    // Reset in the middle of a fill
    bus.mole_on = 3'b100;
    n = 0;
    while (bus.plot !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("arst.started", int'(bus.plot), 1);
    repeat (10) @(negedge clock);
    chk("arst.pre_plot", int'(bus.plot), 1);
    resetn = 1'b0;
    #1;
    chk("arst.plot",  int'(bus.plot),  0);
    chk("arst.drawn", int'(bus.drawn), 0);
    chk("arst.busy",  int'(bus.busy),  0);
    @(negedge clock);
    resetn = 1'b1;
    run_chk("clr2", 0, 160, 0, 120, 3'b000, 2, -1, 0, 3'b000);
    chk("clr2.drawn", int'(bus.drawn), 0);
    chk("clr2.busy",  int'(bus.busy),  1);
    run_chk("m2", 17, 8, 33, 8, 3'b100, 1, -1, 0, 3'b000);
    chk("m2.drawn", int'(bus.drawn), 4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
